// File: rtl/sonar_pkg.sv
// ---------------------------------------------------------------------------
// sonar_pkg
// Shared types and constants for the sonar scan sequencer.
//   state_t            : sequencer FSM states
//   CNT_W              : width of the watchdog / guard counter
//   DIST_W             : width of one distance result
//   SONAR_DEFAULT_FREQ : default system clock frequency in Hz
//   idx_width()        : bits needed to hold a channel index (minimum 1)
//   ptr_width()        : bits needed to hold a scan pointer 0..N (N = past end)
// ---------------------------------------------------------------------------
package sonar_pkg;

    localparam int CNT_W              = 32;
    localparam int DIST_W             = 8;
    localparam int SONAR_DEFAULT_FREQ = 50_000_000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_ISSUE,
        ST_WAIT_RDY,
        ST_GUARD,
        ST_DONE
    } state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // The pointer must also represent N itself, meaning "no channel left".
    function automatic int ptr_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/sonar_scan_sequencer_if.sv
// ---------------------------------------------------------------------------
// sonar_scan_sequencer_if
// Bundles the host control, driver handshake and result-bank signals of the
// sonar scan sequencer.
//   start, continuous, enable_mask  : host scan control
//   drv_measure / drv_ready / drv_distance : per-channel sonar driver handshake
//   dist_out, valid, timeout_err    : per-channel result bank
//   busy, scan_done                 : sequencer status
//   nearest_dist, nearest_idx       : only when SONAR_SEQ_NEAREST_EN is defined
// Modports: master = sequencer side, slave = host / driver side.
// ---------------------------------------------------------------------------
interface sonar_scan_sequencer_if
    import sonar_pkg::*;
#(
    parameter int N_SENSORS = 4
) ();

    logic                          start;
    logic                          continuous;
    logic [N_SENSORS-1:0]          enable_mask;
    logic [N_SENSORS-1:0]          drv_measure;
    logic [N_SENSORS-1:0]          drv_ready;
    logic [DIST_W*N_SENSORS-1:0]   drv_distance;
    logic [DIST_W*N_SENSORS-1:0]   dist_out;
    logic [N_SENSORS-1:0]          valid;
    logic [N_SENSORS-1:0]          timeout_err;
    logic                          busy;
    logic                          scan_done;

`ifdef SONAR_SEQ_NEAREST_EN
    localparam int IDX_W = idx_width(N_SENSORS);
    logic [DIST_W-1:0]             nearest_dist;
    logic [IDX_W-1:0]              nearest_idx;

    modport master (
        input  start, continuous, enable_mask, drv_ready, drv_distance,
        output drv_measure, dist_out, valid, timeout_err, busy, scan_done,
        output nearest_dist, nearest_idx
    );
    modport slave (
        output start, continuous, enable_mask, drv_ready, drv_distance,
        input  drv_measure, dist_out, valid, timeout_err, busy, scan_done,
        input  nearest_dist, nearest_idx
    );
`else
    modport master (
        input  start, continuous, enable_mask, drv_ready, drv_distance,
        output drv_measure, dist_out, valid, timeout_err, busy, scan_done
    );
    modport slave (
        output start, continuous, enable_mask, drv_ready, drv_distance,
        input  drv_measure, dist_out, valid, timeout_err, busy, scan_done
    );
`endif

endinterface

// File: rtl/sonar_next_sel.sv
// ---------------------------------------------------------------------------
// sonar_next_sel
// Combinational priority finder: returns the lowest set index in i_mask that
// is greater than or equal to i_pointer.
//   i_mask    : candidate channels
//   i_pointer : first index allowed (N_SENSORS means none allowed)
//   o_found   : a candidate exists
//   o_index   : lowest qualifying index (0 when none)
// ---------------------------------------------------------------------------
module sonar_next_sel #(
    parameter int N_SENSORS = 4,
    parameter int PTR_W     = 3,
    parameter int IDX_W     = 2
) (
    input  logic [N_SENSORS-1:0] i_mask,
    input  logic [PTR_W-1:0]     i_pointer,
    output logic                 o_found,
    output logic [IDX_W-1:0]     o_index
);

    logic [N_SENSORS-1:0] w_cand;

    generate
        for (genvar gi = 0; gi < N_SENSORS; gi++) begin : g_cand
            assign w_cand[gi] = i_mask[gi] && (PTR_W'(gi) >= i_pointer);
        end
    endgenerate

    // Walk from the top down so the lowest candidate is the last to win.
    always_comb begin
        o_found = 1'b0;
        o_index = '0;
        for (int i = N_SENSORS - 1; i >= 0; i--) begin
            if (w_cand[i]) begin
                o_found = 1'b1;
                o_index = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/sonar_scan_sequencer.sv
// ---------------------------------------------------------------------------
// sonar_scan_sequencer
// Fires N HC-SR04 sonar drivers one at a time in ascending order (skipping
// masked channels), waits for each ready edge under a watchdog, enforces a
// guard gap between pings and latches results into a per-channel bank.
//   clk, rst : system clock, asynchronous active-high reset
//   bus      : sonar_scan_sequencer_if.master (control, driver handshake,
//              result bank, status)
// Optional: define SONAR_SEQ_NEAREST_EN to add nearest_dist / nearest_idx,
// the smallest successful distance, refreshed at the end of every scan.
// ---------------------------------------------------------------------------
module sonar_scan_sequencer
    import sonar_pkg::*;
#(
    parameter int FREQ         = SONAR_DEFAULT_FREQ,
    parameter int N_SENSORS    = 4,
    parameter int GUARD_CYCLES = 3_000_000,
    parameter int WDOG_CYCLES  = 1_500_000
) (
    input  logic                   clk,
    input  logic                   rst,
    sonar_scan_sequencer_if.master bus
);

    localparam int IDX_W = idx_width(N_SENSORS);
    localparam int PTR_W = ptr_width(N_SENSORS);
    localparam logic [CNT_W-1:0] GUARD_LOAD = CNT_W'(GUARD_CYCLES);
    localparam logic [CNT_W-1:0] WDOG_LOAD  = CNT_W'(WDOG_CYCLES);

    // Elaboration-time sanity hook for the timing parameters.
    if (FREQ <= 0 || N_SENSORS < 1 || N_SENSORS > 8) begin : g_param_range_bad
    end

    state_t                 r_state;
    logic [N_SENSORS-1:0]   r_mask;
    logic [N_SENSORS-1:0]   r_measure;
    logic [N_SENSORS-1:0]   r_valid;
    logic [N_SENSORS-1:0]   r_timeout;
    logic [N_SENSORS-1:0]   r_rdy_prev;
    logic [PTR_W-1:0]       r_ptr;
    logic [IDX_W-1:0]       r_sel;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_busy;
    logic                   r_scan_done;
    logic [DIST_W-1:0]      r_dist [N_SENSORS];
    logic [DIST_W-1:0]      w_drv_dist [N_SENSORS];

    logic                   w_found;
    logic [IDX_W-1:0]       w_idx;
    logic                   w_edge;

    sonar_next_sel #(
        .N_SENSORS (N_SENSORS),
        .PTR_W     (PTR_W),
        .IDX_W     (IDX_W)
    ) u_next_sel (
        .i_mask    (r_mask),
        .i_pointer (r_ptr),
        .o_found   (w_found),
        .o_index   (w_idx)
    );

    generate
        for (genvar gi = 0; gi < N_SENSORS; gi++) begin : g_lane
            assign w_drv_dist[gi]                   = bus.drv_distance[gi*DIST_W +: DIST_W];
            assign bus.dist_out[gi*DIST_W +: DIST_W] = r_dist[gi];
        end
    endgenerate

    // Only the selected channel's ready line can complete a measurement.
    assign w_edge = bus.drv_ready[r_sel] & ~r_rdy_prev[r_sel];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_mask      <= '0;
            r_measure   <= '0;
            r_valid     <= '0;
            r_timeout   <= '0;
            r_rdy_prev  <= '0;
            r_ptr       <= '0;
            r_sel       <= '0;
            r_cnt       <= '0;
            r_busy      <= 1'b0;
            r_scan_done <= 1'b0;
            for (int i = 0; i < N_SENSORS; i++) begin
                r_dist[i] <= '0;
            end
        end else begin
            r_rdy_prev  <= bus.drv_ready;
            r_scan_done <= 1'b0;
            r_measure   <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start || bus.continuous) begin
                        r_mask  <= bus.enable_mask;
                        r_ptr   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_SELECT;
                    end
                end
                ST_SELECT: begin
                    if (w_found) begin
                        r_sel     <= w_idx;
                        // Raised here so the pulse coincides with the ISSUE cycle.
                        r_measure <= N_SENSORS'(1) << w_idx;
                        r_state   <= ST_ISSUE;
                    end else begin
                        r_scan_done <= 1'b1;
                        r_state     <= ST_DONE;
                    end
                end
                ST_ISSUE: begin
                    r_cnt   <= WDOG_LOAD;
                    r_state <= ST_WAIT_RDY;
                end
                ST_WAIT_RDY: begin
                    // A ready edge wins over a simultaneous watchdog expiry.
                    if (w_edge) begin
                        r_dist[r_sel]    <= w_drv_dist[r_sel];
                        r_valid[r_sel]   <= 1'b1;
                        r_timeout[r_sel] <= 1'b0;
                        r_cnt            <= GUARD_LOAD;
                        r_state          <= ST_GUARD;
                    end else if (r_cnt == '0) begin
                        r_timeout[r_sel] <= 1'b1;
                        r_cnt            <= GUARD_LOAD;
                        r_state          <= ST_GUARD;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_GUARD: begin
                    if (r_cnt == '0) begin
                        r_ptr   <= PTR_W'(r_sel) + PTR_W'(1);
                        r_state <= ST_SELECT;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_DONE: begin
                    if (bus.continuous) begin
                        r_mask  <= bus.enable_mask;
                        r_ptr   <= '0;
                        r_state <= ST_SELECT;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.drv_measure = r_measure;
    assign bus.valid       = r_valid;
    assign bus.timeout_err = r_timeout;
    assign bus.busy        = r_busy;
    assign bus.scan_done   = r_scan_done;

`ifdef SONAR_SEQ_NEAREST_EN
    logic [N_SENSORS-1:0]   w_qual;
    logic                   w_q_found;
    logic [IDX_W-1:0]       w_q_idx;
    logic [PTR_W-1:0]       w_zero_ptr;
    logic [DIST_W-1:0]      w_best_dist;
    logic [IDX_W-1:0]       w_best_idx;
    logic [DIST_W-1:0]      r_near_dist;
    logic [IDX_W-1:0]       r_near_idx;

    generate
        for (genvar gi = 0; gi < N_SENSORS; gi++) begin : g_qual
            assign w_qual[gi] = r_valid[gi] & ~r_timeout[gi];
        end
    endgenerate

    assign w_zero_ptr = '0;

    // The lowest qualifying channel seeds the search; a strict less-than
    // below then keeps ties on the lower index.
    sonar_next_sel #(
        .N_SENSORS (N_SENSORS),
        .PTR_W     (PTR_W),
        .IDX_W     (IDX_W)
    ) u_first_qual (
        .i_mask    (w_qual),
        .i_pointer (w_zero_ptr),
        .o_found   (w_q_found),
        .o_index   (w_q_idx)
    );

    always_comb begin
        w_best_dist = r_dist[w_q_idx];
        w_best_idx  = w_q_idx;
        for (int i = 0; i < N_SENSORS; i++) begin
            if (w_qual[i] && (r_dist[i] < w_best_dist)) begin
                w_best_dist = r_dist[i];
                w_best_idx  = IDX_W'(i);
            end
        end
        if (!w_q_found) begin
            w_best_dist = 8'hFF;
            w_best_idx  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_near_dist <= 8'hFF;
            r_near_idx  <= '0;
        end else if (r_state == ST_DONE) begin
            r_near_dist <= w_best_dist;
            r_near_idx  <= w_best_idx;
        end
    end

    assign bus.nearest_dist = r_near_dist;
    assign bus.nearest_idx  = r_near_idx;
`else
    // Nearest-distance reduction not built in this configuration.
`endif

endmodule

// File: tb/tb_sonar_scan_sequencer.sv
// ---------------------------------------------------------------------------
// tb_sonar_scan_sequencer
// Self-checking bench: per-channel driver models answer each measure pulse
// with a ready edge after a programmable delay; a scoreboard queue holds the
// expected order and spacing of measure pulses and is drained by a monitor.
// ---------------------------------------------------------------------------
module tb_sonar_scan_sequencer;
    import sonar_pkg::*;

    localparam int N        = 4;
    localparam int GUARD    = 50;
    localparam int WDOG     = 200;
    localparam int DELAY    = 100;                 // ready rises after 100 idle cycles
    localparam int GAP_OK   = DELAY + GUARD + 4;   // measure-to-measure, answered channel
    localparam int GAP_TO   = WDOG + GUARD + 4;    // measure-to-measure, timed-out channel
    localparam int GAP_WRAP = GAP_OK + 2;          // across DONE into the next scan
    localparam int BUDGET   = 5000;

    typedef struct {
        int ch;
        int gap;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sonar_scan_sequencer_if #(.N_SENSORS(N)) bus ();

    sonar_scan_sequencer #(
        .FREQ         (50_000_000),
        .N_SENSORS    (N),
        .GUARD_CYCLES (GUARD),
        .WDOG_CYCLES  (WDOG)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          n_cmp     = 0;
    int          n_bad     = 0;
    int          cyc       = 0;
    int          last_meas = 0;
    int          done_cnt  = 0;
    int          resp_delay [N];
    logic [7:0]  dist_val   [N];
    int          rdy_cnt    [N];
    exp_t        exp_q [$];

    // Driver models: a measure pulse drops ready; ready rises after
    // resp_delay full cycles following the pulse (0 = never answers).
    initial begin
        bus.drv_ready    = '0;
        bus.drv_distance = '0;
        for (int k = 0; k < N; k++) rdy_cnt[k] = 0;
        forever begin
            @(negedge clk);
            for (int k = 0; k < N; k++) begin
                bus.drv_distance[k*8 +: 8] = dist_val[k];
                if (bus.drv_measure[k]) begin
                    bus.drv_ready[k] = 1'b0;
                    rdy_cnt[k] = (resp_delay[k] > 0) ? resp_delay[k] + 1 : 0;
                end else if (rdy_cnt[k] > 0) begin
                    rdy_cnt[k]--;
                    if (rdy_cnt[k] == 0) bus.drv_ready[k] = 1'b1;
                end
            end
        end
    end

    // Scoreboard monitor: every measure pulse must match the next expectation.
    always @(negedge clk) begin
        exp_t       e;
        logic [N-1:0] one_hot;
        cyc++;
        if (bus.scan_done) done_cnt++;
        if (!rst && bus.drv_measure != '0) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_measure: got %b, required none", bus.drv_measure);
            end else begin
                e = exp_q.pop_front();
                one_hot = N'(1) << e.ch;
                $display("measure ch=%0d pulse=%b cycle=%0d", e.ch, bus.drv_measure, cyc);
                if (bus.drv_measure !== one_hot) begin
                    n_bad++;
                    $display("FAIL measure_onehot: got %b, required %b", bus.drv_measure, one_hot);
                end
                if (e.gap >= 0) begin
                    n_cmp++;
                    if ((cyc - last_meas) !== e.gap) begin
                        n_bad++;
                        $display("FAIL measure_gap ch%0d: got %0d, required %0d", e.ch, cyc - last_meas, e.gap);
                    end
                end
            end
            last_meas = cyc;
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < BUDGET && !seen; i++) begin
            if (bus.scan_done) seen = 1'b1;
            else @(negedge clk);
        end
        n_cmp++;
        if (!seen) begin
            n_bad++;
            $display("FAIL %s_scan_done: got no pulse, required one within %0d cycles", tag, BUDGET);
        end
    endtask

    task automatic set_channels(input logic [7:0] d0, d1, d2, d3);
        dist_val[0] = d0; dist_val[1] = d1; dist_val[2] = d2; dist_val[3] = d3;
        for (int k = 0; k < N; k++) resp_delay[k] = DELAY;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_cmp += 6;
        if (bus.dist_out !== '0)    begin n_bad++; $display("FAIL rst_dist: got %h, required 0", bus.dist_out); end
        if (bus.valid !== '0)       begin n_bad++; $display("FAIL rst_valid: got %b, required 0", bus.valid); end
        if (bus.timeout_err !== '0) begin n_bad++; $display("FAIL rst_timeout: got %b, required 0", bus.timeout_err); end
        if (bus.busy !== 1'b0)      begin n_bad++; $display("FAIL rst_busy: got %b, required 0", bus.busy); end
        if (bus.scan_done !== 1'b0) begin n_bad++; $display("FAIL rst_done: got %b, required 0", bus.scan_done); end
        if (bus.drv_measure !== '0) begin n_bad++; $display("FAIL rst_measure: got %b, required 0", bus.drv_measure); end
        rst = 1'b0;
        $display("reset released at cycle %0d", cyc);
    endtask

    task automatic test_zero_mask();
        int cnt = 1;
        bus.enable_mask = '0;
        pulse_start();
        while (!bus.scan_done && cnt < 10) begin
            @(negedge clk);
            cnt++;
        end
        n_cmp++;
        if (cnt !== 2) begin n_bad++; $display("FAIL zero_mask_latency: got %0d, required 2", cnt); end
        @(negedge clk);
        n_cmp++;
        if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL zero_mask_idle: got busy=%b, required 0", bus.busy); end
        $display("zero-mask scan done in %0d cycles", cnt);
    endtask

    task automatic test_full_scan();
        int d0;
        set_channels(8'd10, 8'd20, 8'd30, 8'd40);
        bus.enable_mask = 4'b1111;
        exp_q.push_back('{0, -1});
        exp_q.push_back('{1, GAP_OK});
        exp_q.push_back('{2, GAP_OK});
        exp_q.push_back('{3, GAP_OK});
        d0 = done_cnt;
        pulse_start();
        wait_done("full");
        @(negedge clk);
        n_cmp += 6;
        if (exp_q.size() !== 0)          begin n_bad++; $display("FAIL full_pending: got %0d left, required 0", exp_q.size()); end
        if (bus.dist_out !== 32'h281E140A) begin n_bad++; $display("FAIL full_dist: got %h, required 281e140a", bus.dist_out); end
        if (bus.valid !== 4'hF)          begin n_bad++; $display("FAIL full_valid: got %b, required 1111", bus.valid); end
        if (bus.timeout_err !== 4'h0)    begin n_bad++; $display("FAIL full_timeout: got %b, required 0000", bus.timeout_err); end
        if (done_cnt - d0 !== 1)         begin n_bad++; $display("FAIL full_done_count: got %0d, required 1", done_cnt - d0); end
        if (bus.busy !== 1'b0)           begin n_bad++; $display("FAIL full_idle: got busy=%b, required 0", bus.busy); end
        $display("full scan dist=%h valid=%b", bus.dist_out, bus.valid);
    endtask

    task automatic test_timeout();
        set_channels(8'd11, 8'd21, 8'd31, 8'd41);
        resp_delay[1] = 0;
        bus.enable_mask = 4'b1111;
        exp_q.push_back('{0, -1});
        exp_q.push_back('{1, GAP_OK});
        exp_q.push_back('{2, GAP_TO});
        exp_q.push_back('{3, GAP_OK});
        pulse_start();
        wait_done("timeout");
        @(negedge clk);
        n_cmp += 4;
        if (exp_q.size() !== 0)            begin n_bad++; $display("FAIL to_pending: got %0d left, required 0", exp_q.size()); end
        if (bus.timeout_err !== 4'b0010)   begin n_bad++; $display("FAIL to_flags: got %b, required 0010", bus.timeout_err); end
        if (bus.dist_out !== 32'h291F140B) begin n_bad++; $display("FAIL to_dist: got %h, required 291f140b", bus.dist_out); end
        if (bus.valid !== 4'hF)            begin n_bad++; $display("FAIL to_valid: got %b, required 1111", bus.valid); end
        resp_delay[1] = DELAY;
        $display("timeout scan flags=%b dist=%h", bus.timeout_err, bus.dist_out);
    endtask

    task automatic test_mask();
        apply_reset();
        set_channels(8'd10, 8'd20, 8'd30, 8'd40);
        bus.enable_mask = 4'b0101;
        exp_q.push_back('{0, -1});
        exp_q.push_back('{2, GAP_OK});
        pulse_start();
        wait_done("mask");
        @(negedge clk);
        n_cmp += 3;
        if (exp_q.size() !== 0)            begin n_bad++; $display("FAIL mask_pending: got %0d left, required 0", exp_q.size()); end
        if (bus.valid !== 4'b0101)         begin n_bad++; $display("FAIL mask_valid: got %b, required 0101", bus.valid); end
        if (bus.dist_out !== 32'h001E000A) begin n_bad++; $display("FAIL mask_dist: got %h, required 001e000a", bus.dist_out); end
        $display("masked scan valid=%b dist=%h", bus.valid, bus.dist_out);
    endtask

    task automatic test_back_to_back();
        bit saw_idle = 1'b0;
        set_channels(8'd10, 8'd20, 8'd30, 8'd40);
        bus.enable_mask = 4'b0011;
        exp_q.push_back('{0, -1});
        exp_q.push_back('{1, GAP_OK});
        exp_q.push_back('{0, GAP_WRAP});
        exp_q.push_back('{1, GAP_OK});
        @(negedge clk);
        bus.continuous = 1'b1;
        @(negedge clk);
        wait_done("cont_first");
        n_cmp++;
        if (bus.dist_out[7:0] !== 8'd10) begin n_bad++; $display("FAIL cont_first_dist0: got %0d, required 10", bus.dist_out[7:0]); end
        @(negedge clk);
        if (bus.busy !== 1'b1) saw_idle = 1'b1;
        bus.continuous = 1'b0;
        dist_val[0]    = 8'd55;
        @(negedge clk);
        for (int i = 0; i < BUDGET && !bus.scan_done; i++) begin
            if (bus.busy !== 1'b1) saw_idle = 1'b1;
            @(negedge clk);
        end
        wait_done("cont_second");
        @(negedge clk);
        n_cmp += 4;
        if (saw_idle)                     begin n_bad++; $display("FAIL cont_no_idle: got idle gap, required none"); end
        if (bus.dist_out[7:0] !== 8'd55)  begin n_bad++; $display("FAIL cont_dist0: got %0d, required 55", bus.dist_out[7:0]); end
        if (exp_q.size() !== 0)           begin n_bad++; $display("FAIL cont_pending: got %0d left, required 0", exp_q.size()); end
        if (bus.busy !== 1'b0)            begin n_bad++; $display("FAIL cont_idle_after: got busy=%b, required 0", bus.busy); end
        $display("continuous scans dist0=%0d", bus.dist_out[7:0]);
    endtask

    task automatic test_reset_midscan();
        bit seen = 1'b0;
        set_channels(8'd10, 8'd20, 8'd30, 8'd40);
        bus.enable_mask = 4'b1111;
        exp_q.push_back('{0, -1});
        exp_q.push_back('{1, GAP_OK});
        exp_q.push_back('{2, GAP_OK});
        pulse_start();
        for (int i = 0; i < BUDGET && !seen; i++) begin
            if (bus.drv_measure[2]) seen = 1'b1;
            else @(negedge clk);
        end
        n_cmp++;
        if (!seen) begin n_bad++; $display("FAIL mid_reach_ch2: got no measure on ch2, required one"); end
        repeat (20) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_cmp += 5;
        if (bus.busy !== 1'b0)      begin n_bad++; $display("FAIL mid_busy: got %b, required 0", bus.busy); end
        if (bus.valid !== '0)       begin n_bad++; $display("FAIL mid_valid: got %b, required 0", bus.valid); end
        if (bus.dist_out !== '0)    begin n_bad++; $display("FAIL mid_dist: got %h, required 0", bus.dist_out); end
        if (bus.timeout_err !== '0) begin n_bad++; $display("FAIL mid_timeout: got %b, required 0", bus.timeout_err); end
        if (bus.drv_measure !== '0) begin n_bad++; $display("FAIL mid_measure: got %b, required 0", bus.drv_measure); end
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        $display("reset during WAIT_RDY of ch2, restarting");
        exp_q.push_back('{0, -1});
        exp_q.push_back('{1, GAP_OK});
        exp_q.push_back('{2, GAP_OK});
        exp_q.push_back('{3, GAP_OK});
        pulse_start();
        wait_done("resume");
        @(negedge clk);
        n_cmp += 2;
        if (exp_q.size() !== 0) begin n_bad++; $display("FAIL resume_pending: got %0d left, required 0", exp_q.size()); end
        if (bus.valid !== 4'hF) begin n_bad++; $display("FAIL resume_valid: got %b, required 1111", bus.valid); end
    endtask

`ifdef SONAR_SEQ_NEAREST_EN
    task automatic test_nearest();
        apply_reset();
        n_cmp += 2;
        if (bus.nearest_dist !== 8'hFF) begin n_bad++; $display("FAIL near_rst_dist: got %h, required ff", bus.nearest_dist); end
        if (bus.nearest_idx !== 2'd0)   begin n_bad++; $display("FAIL near_rst_idx: got %0d, required 0", bus.nearest_idx); end
        set_channels(8'd90, 8'd7, 8'd7, 8'd40);
        bus.enable_mask = 4'b1111;
        exp_q.push_back('{0, -1});
        exp_q.push_back('{1, GAP_OK});
        exp_q.push_back('{2, GAP_OK});
        exp_q.push_back('{3, GAP_OK});
        pulse_start();
        wait_done("nearest");
        @(negedge clk);
        n_cmp += 2;
        if (bus.nearest_dist !== 8'd7) begin n_bad++; $display("FAIL near_dist: got %0d, required 7", bus.nearest_dist); end
        if (bus.nearest_idx !== 2'd1)  begin n_bad++; $display("FAIL near_idx: got %0d, required 1", bus.nearest_idx); end
        $display("nearest dist=%0d idx=%0d", bus.nearest_dist, bus.nearest_idx);
    endtask
`endif

    initial begin
        bus.start       = 1'b0;
        bus.continuous  = 1'b0;
        bus.enable_mask = '0;
        set_channels(8'd0, 8'd0, 8'd0, 8'd0);
        test_reset();
        test_zero_mask();
        test_full_scan();
        test_timeout();
        test_mask();
        test_back_to_back();
        test_reset_midscan();
`ifdef SONAR_SEQ_NEAREST_EN
        test_nearest();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "global timeout");
    end

endmodule
